// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and helpers for the keypad scan encoder.
//   state_t      : encoder FSM states
//   NULL_CODE    : code driven on D when no key has been accepted
//   onehot_t     : result of onehot_index (valid flag + bit index)
//   onehot_index : classifies a key vector as exactly-one-hot and
//                  returns the index of the set bit
// Vectors narrower than MAX_KEYS are zero-extended by the caller.

package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam int NULL_CODE = 0;

    // Widest keypad the helper function can classify.
    localparam int MAX_KEYS = 64;
    localparam int INDEX_W  = 6;

    typedef struct packed {
        logic               valid;
        logic [INDEX_W-1:0] index;
    } onehot_t;

    // valid is set only when exactly one bit is high; all-zero and
    // multi-hot vectors both report invalid. index is meaningful only
    // when valid is set.
    function automatic onehot_t onehot_index(input logic [MAX_KEYS-1:0] vec);
        onehot_t     result;
        int unsigned ones;
        result.valid = 1'b0;
        result.index = '0;
        ones         = 0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (vec[i]) begin
                ones++;
                result.index = INDEX_W'(i);
            end
        end
        result.valid = (ones == 1);
        return result;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchroniser for a bus of asynchronous, independently
// changing lines (each bit is synchronised on its own; the bus is not
// treated as a coherent word).
// Ports:
//   clk    : sampling clock
//   resetn : synchronous active-low reset, clears both flop stages
//   raw    : asynchronous input lines
//   synced : lines after two flop stages

module keypad_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second stage gives it a full
    // cycle to resolve before anything downstream looks at it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
// Synchronises and debounces a one-hot keypad, rejects multi-key
// presses and emits the key code with a one-cycle active-low load
// strobe for the time-entry register.
// Ports:
//   clk     : single clock, all state on the rising edge
//   resetn  : synchronous active-low reset
//   keypad  : raw asynchronous key lines, bit i = key i, active-high
//   enablen : active-low enable; high forces IDLE, D = 0, no strobe
//   D       : code of the last accepted key, held between strobes
//   loadn   : active-low one-cycle strobe, D valid while low
//   busy    : high whenever the FSM is not IDLE
// Build option:
//   KEYPAD_REPEAT_EN : when defined, a held key re-issues the strobe
//                      every REPEAT_CYCLES cycles.

module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 500
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic [CODE_W-1:0]   D,
    output logic                loadn,
    output logic                busy
);

    // One counter serves both debouncing and, in HELD, the repeat
    // period, so it is sized for the larger of the two.
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                             DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DB_DONE  = CNT_W'(DEBOUNCE_CYCLES);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [NUM_KEYS-1:0] s;
    logic [MAX_KEYS-1:0] s_wide;
    onehot_t             s_info;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [NUM_KEYS-1:0] candidate;
    logic [NUM_KEYS-1:0] candidate_next;
    logic [CODE_W-1:0]   code_next;
    logic                loadn_next;

    // Saturating increment: the counter must never wrap back to a small
    // value that could look like a fresh debounce count.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_FULL) ? value : value + CNT_ONE;
    endfunction

    keypad_sync #(
        .WIDTH (NUM_KEYS)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .raw    (keypad),
        .synced (s)
    );

    assign s_wide = MAX_KEYS'(s);
    assign s_info = onehot_index(s_wide);
    assign busy   = (state != IDLE);

    // State, counter, candidate key and both outputs are all registered
    // so D and loadn change together and are glitch-free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            candidate <= '0;
            D         <= CODE_W'(NULL_CODE);
            loadn     <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            candidate <= candidate_next;
            D         <= code_next;
            loadn     <= loadn_next;
        end
    end

    // Next-state logic. Disable overrides every FSM transition. While
    // pressing, s equals the candidate on the accepting cycle, so the
    // code is taken from the index of s. HELD deliberately ignores any
    // non-zero change of s (extra or different keys) - only a full
    // release leaves it, and only a debounced release reaches IDLE.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        candidate_next = candidate;
        code_next      = D;
        loadn_next     = 1'b1;

        if (enablen) begin
            state_next = IDLE;
            cnt_next   = '0;
            code_next  = CODE_W'(NULL_CODE);
        end else begin
            case (state)
                IDLE: begin
                    if (s_info.valid) begin
                        candidate_next = s;
                        cnt_next       = CNT_ONE;
                        state_next     = PRESS_DB;
                    end
                end

                PRESS_DB: begin
                    if (s != candidate) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else if (cnt == DB_DONE) begin
                        code_next  = CODE_W'(s_info.index);
                        loadn_next = 1'b0;
                        cnt_next   = '0;
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt_inc(cnt);
                    end
                end

                HELD: begin
                    if (s == '0) begin
                        cnt_next   = CNT_ONE;
                        state_next = RELEASE_DB;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (cnt == REPEAT_LAST) begin
                        loadn_next = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc(cnt);
                    end
`endif
                end

                RELEASE_DB: begin
                    if (s != '0) begin
                        // Re-entering HELD restarts the repeat period.
                        cnt_next   = '0;
                        state_next = HELD;
                    end else if (cnt == DB_DONE) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_inc(cnt);
                    end
                end

                default: begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder
// Self-checking bench for keypad_scan_encoder with DEBOUNCE_CYCLES = 4
// and REPEAT_CYCLES = 8. A timestamp-based reference model predicts
// loadn, D and busy after every clock edge; directed sequences add
// fixed-value checks for press latency, release timing and repeats.
// Honours KEYPAD_REPEAT_EN the same way the design does.

module tb_keypad_scan_encoder;

    localparam int NUM_KEYS = 10;
    localparam int CODE_W   = 4;
    localparam int DB       = 4;
    localparam int RC       = 8;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    // Phases of the keypad as the model sees it.
    localparam int WAITING   = 0;
    localparam int PRESSING  = 1;
    localparam int HOLDING   = 2;
    localparam int RELEASING = 3;

    logic                clk     = 1'b0;
    logic                resetn  = 1'b0;
    logic [NUM_KEYS-1:0] keypad  = '0;
    logic                enablen = 1'b0;
    logic [CODE_W-1:0]   d_out;
    logic                loadn;
    logic                busy;

    int check_count = 0;
    int fail_count  = 0;
    int edge_num    = 0;

    // Reference model state
    logic [NUM_KEYS-1:0] kp_hist[$];
    int                  phase     = WAITING;
    logic [NUM_KEYS-1:0] cand_m    = '0;
    int                  mark      = 0;
    logic                exp_loadn = 1'b1;
    int                  exp_d     = 0;
    logic                exp_busy  = 1'b0;

    keypad_scan_encoder #(
        .NUM_KEYS        (NUM_KEYS),
        .CODE_W          (CODE_W),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .keypad  (keypad),
        .enablen (enablen),
        .D       (d_out),
        .loadn   (loadn),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d",
                     tag, edge_num, observed, expected);
        end
    endtask

    function automatic int key_index(input logic [NUM_KEYS-1:0] v);
        int idx = 0;
        for (int i = 0; i < NUM_KEYS; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // Advances the model by one clock edge. The debouncer sees keypad
    // values two edges late; a press is accepted DB edges after the
    // first clean one-hot sample if every sample in between matched.
    task automatic model_edge(input logic [NUM_KEYS-1:0] kp, input logic en_n,
                              input logic rst_n);
        logic [NUM_KEYS-1:0] s;
        s = kp_hist.pop_front();
        kp_hist.push_back(kp);
        exp_loadn = 1'b1;
        if (!rst_n) begin
            kp_hist.delete();
            kp_hist.push_back('0);
            kp_hist.push_back('0);
            phase = WAITING;
            exp_d = 0;
        end else if (en_n) begin
            phase = WAITING;
            exp_d = 0;
        end else if (phase == WAITING) begin
            if ($countones(s) == 1) begin
                cand_m = s;
                mark   = edge_num;
                phase  = PRESSING;
            end
        end else if (phase == PRESSING) begin
            if (s != cand_m) begin
                phase = WAITING;
            end else if (edge_num - mark == DB) begin
                exp_d     = key_index(cand_m);
                exp_loadn = 1'b0;
                mark      = edge_num;
                phase     = HOLDING;
            end
        end else if (phase == HOLDING) begin
            if (s == '0) begin
                mark  = edge_num;
                phase = RELEASING;
            end else if (REPEAT_ON && ((edge_num - mark) % RC == 0)) begin
                exp_loadn = 1'b0;
            end
        end else begin
            if (s != '0) begin
                mark  = edge_num;
                phase = HOLDING;
            end else if (edge_num - mark == DB) begin
                phase = WAITING;
            end
        end
        exp_busy = (phase != WAITING);
    endtask

    // One clock cycle: drive inputs (at the falling edge), let the
    // rising edge happen, advance the model, compare at the next fall.
    task automatic applyStimulus(input logic [NUM_KEYS-1:0] kp, input logic en_n,
                                 input logic rst_n);
        keypad  = kp;
        enablen = en_n;
        resetn  = rst_n;
        @(posedge clk);
        edge_num++;
        model_edge(kp, en_n, rst_n);
        @(negedge clk);
        checkOutput("loadn", {31'd0, loadn}, {31'd0, exp_loadn});
        checkOutput("D", {28'd0, d_out}, exp_d);
        checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
    endtask

    task automatic runEpisode(input int kind);
        int                  key;
        int                  key2;
        int                  hold;
        logic [NUM_KEYS-1:0] k;
        logic [NUM_KEYS-1:0] k2;
        key  = $urandom_range(0, NUM_KEYS - 1);
        key2 = (key + 1 + $urandom_range(0, NUM_KEYS - 2)) % NUM_KEYS;
        hold = $urandom_range(1, 30);
        k    = NUM_KEYS'(1) << key;
        k2   = NUM_KEYS'(1) << key2;
        case (kind)
            0: repeat (hold) applyStimulus(k, 1'b0, 1'b1);
            1: begin
                for (int c = 0; c < 10; c++)
                    applyStimulus(((c / 2) % 2 == 0) ? k : '0, 1'b0, 1'b1);
                repeat (hold) applyStimulus(k, 1'b0, 1'b1);
            end
            2: begin
                repeat (6) applyStimulus(k | k2, 1'b0, 1'b1);
                repeat (hold + 6) applyStimulus(k, 1'b0, 1'b1);
            end
            3: begin
                repeat (8) applyStimulus(NUM_KEYS'(1), 1'b0, 1'b1);
                repeat (hold) applyStimulus(NUM_KEYS'(1) | (NUM_KEYS'(1) << 9),
                                            1'b0, 1'b1);
            end
            4: begin
                repeat (3) applyStimulus(k, 1'b0, 1'b1);
                repeat (3) applyStimulus(k, 1'b1, 1'b1);
                repeat (hold + 8) applyStimulus(k, 1'b0, 1'b1);
            end
            default: begin
                repeat (8) applyStimulus(k, 1'b0, 1'b1);
                repeat (hold) applyStimulus(k | k2, 1'b0, 1'b1);
            end
        endcase
        repeat ($urandom_range(0, 8)) applyStimulus('0, 1'b0, 1'b1);
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) applyStimulus(k, 1'b0, 1'b1);
        if ($urandom_range(0, 19) == 0)
            repeat (2) applyStimulus(k, 1'b0, 1'b0);
        repeat (8) applyStimulus('0, 1'b0, 1'b1);
    endtask

    logic obs_loadn[40];
    int   obs_d[40];
    logic obs_busy[12];
    int   strobes;

    initial begin
        kp_hist.push_back('0);
        kp_hist.push_back('0);

        // Reset and idle
        repeat (3) applyStimulus('0, 1'b0, 1'b0);
        checkOutput("reset_loadn", {31'd0, loadn}, 32'd1);
        checkOutput("reset_D", {28'd0, d_out}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) applyStimulus('0, 1'b0, 1'b1);

        // Key 7 stable from edge 0: strobe only after edge 2 + DB
        for (int e = 0; e < 13; e++) begin
            applyStimulus(NUM_KEYS'(1) << 7, 1'b0, 1'b1);
            obs_loadn[e] = loadn;
            obs_d[e]     = int'(d_out);
        end
        for (int e = 0; e < 13; e++)
            checkOutput("key7_loadn", {31'd0, obs_loadn[e]},
                        (e == 2 + DB) ? 32'd0 : 32'd1);
        checkOutput("key7_D", obs_d[2 + DB], 32'd7);

        // Release: s clears at release edge 2, IDLE DB edges later
        for (int e = 0; e < 12; e++) begin
            applyStimulus('0, 1'b0, 1'b1);
            obs_busy[e] = busy;
        end
        for (int e = 0; e < 12; e++)
            checkOutput("release_busy", {31'd0, obs_busy[e]},
                        (e < 2 + DB) ? 32'd1 : 32'd0);

        // Key 6 held 30 cycles past the first strobe
        for (int e = 0; e < 37; e++) begin
            applyStimulus(NUM_KEYS'(1) << 6, 1'b0, 1'b1);
            obs_loadn[e] = loadn;
            obs_d[e]     = int'(d_out);
        end
        strobes = 0;
        for (int e = 2 + DB + 1; e < 37; e++)
            if (!obs_loadn[e]) strobes++;
        checkOutput("key6_first", {31'd0, obs_loadn[2 + DB]}, 32'd0);
        checkOutput("key6_D", obs_d[36], 32'd6);
        checkOutput("repeat_count", strobes, REPEAT_ON ? 32'd3 : 32'd0);
        repeat (10) applyStimulus('0, 1'b0, 1'b1);

        // Every scenario once, then random episodes
        for (int kind = 0; kind < 6; kind++) runEpisode(kind);
        for (int n = 0; n < 150; n++) runEpisode($urandom_range(0, 5));

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
